// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the 5-stage CPU.
// Latches decoder controls, operands, immediate and register addresses,
// detects load-use hazards against the instruction in ID, inserts bubbles
// on hazard or branch flush, and counts both events in saturating counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Decoder controls from ID
  input  logic              RegWrite_i,
  input  logic [2:0]        ALU_op_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              Branch_i,
  input  logic              BranchType_i,
  input  logic              MemToReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  // Datapath from ID
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs_addr_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  // Pipeline control
  input  logic              stall_i,
  input  logic              flush_i,
  // Registered copies for EX
  output logic              RegWrite_o,
  output logic [2:0]        ALU_op_o,
  output logic              ALUSrc_o,
  output logic              RegDst_o,
  output logic              Branch_o,
  output logic              BranchType_o,
  output logic              MemToReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        rs_addr_o,
  output logic [4:0]        rt_addr_o,
  output logic [4:0]        rd_addr_o,
  // Status and front-end control
  output logic              valid_o,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Everything that crosses the ID/EX boundary, bundled so a bubble is '0.
  typedef struct packed {
    logic              regWrite;
    logic [2:0]        aluOp;
    logic              aluSrc;
    logic              regDst;
    logic              branch;
    logic              branchType;
    logic              memToReg;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] pcPlus4;
    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rsAddr;
    logic [4:0]        rtAddr;
    logic [4:0]        rdAddr;
  } idEx_t;

  idEx_t            idIn;
  idEx_t            exQ;
  logic             validQ;
  logic             usesRt;
  logic             hazard;
  logic [CNT_W-1:0] bubbleCnt;
  logic [CNT_W-1:0] flushCnt;

  // Gather the ID-stage inputs into one bundle.
  always_comb begin
    // NOTE: every field is assigned on every evaluation, so no latch is inferred.
    idIn.regWrite   = RegWrite_i;
    idIn.aluOp      = ALU_op_i;
    idIn.aluSrc     = ALUSrc_i;
    idIn.regDst     = RegDst_i;
    idIn.branch     = Branch_i;
    idIn.branchType = BranchType_i;
    idIn.memToReg   = MemToReg_i;
    idIn.memRead    = MemRead_i;
    idIn.memWrite   = MemWrite_i;
    idIn.pcPlus4    = pc_plus4_i;
    idIn.rsData     = rs_data_i;
    idIn.rtData     = rt_data_i;
    idIn.imm        = imm_i;
    idIn.rsAddr     = rs_addr_i;
    idIn.rtAddr     = rt_addr_i;
    idIn.rdAddr     = rd_addr_i;
  end

  // Load-use detection: a load in EX whose destination the ID instruction reads.
  always_comb begin
    // rt is a source only for R-type, branches and stores; otherwise it is a destination.
    usesRt = RegDst_i | Branch_i | MemWrite_i;
    hazard = validQ & exQ.memRead & (exQ.rtAddr != 5'd0) &
             ((exQ.rtAddr == rs_addr_i) | (usesRt & (exQ.rtAddr == rt_addr_i)));
  end

  // Pipeline register: flush beats stall beats hazard bubble beats capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: plain flops only (no memory array), so every bit takes the async reset.
    if (rst_i) begin
      exQ    <= '0;
      validQ <= 1'b0;
    end else if (flush_i) begin
      // NOTE: non-blocking assignments keep all state updating together at the edge.
      exQ    <= '0;
      validQ <= 1'b0;
    end else if (stall_i) begin
      exQ    <= exQ;
      validQ <= validQ;
    end else if (hazard) begin
      exQ    <= '0;
      validQ <= 1'b0;
    end else begin
      exQ    <= idIn;
      validQ <= 1'b1;
    end
  end

  // Saturating event counters, following the same priority as the register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubbleCnt <= '0;
      flushCnt  <= '0;
    end else if (flush_i) begin
      if (flushCnt != CNT_MAX) flushCnt <= flushCnt + CNT_ONE;
    end else if (!stall_i && hazard) begin
      if (bubbleCnt != CNT_MAX) bubbleCnt <= bubbleCnt + CNT_ONE;
    end
  end

  // Front-end write enables; the PC mux handles flush redirection itself.
  assign pc_write_o   = ~(hazard | stall_i) & ~rst_i;
  assign ifid_write_o = ~(hazard | stall_i) & ~rst_i;
  assign hazard_o     = hazard;

  assign RegWrite_o   = exQ.regWrite;
  assign ALU_op_o     = exQ.aluOp;
  assign ALUSrc_o     = exQ.aluSrc;
  assign RegDst_o     = exQ.regDst;
  assign Branch_o     = exQ.branch;
  assign BranchType_o = exQ.branchType;
  assign MemToReg_o   = exQ.memToReg;
  assign MemRead_o    = exQ.memRead;
  assign MemWrite_o   = exQ.memWrite;
  assign pc_plus4_o   = exQ.pcPlus4;
  assign rs_data_o    = exQ.rsData;
  assign rt_data_o    = exQ.rtData;
  assign imm_o        = exQ.imm;
  assign rs_addr_o    = exQ.rsAddr;
  assign rt_addr_o    = exQ.rtAddr;
  assign rd_addr_o    = exQ.rdAddr;
  assign valid_o      = validQ;
  assign bubble_cnt_o = bubbleCnt;
  assign flush_cnt_o  = flushCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (CNT_W = 4 so saturation is reachable).
module tb_id_ex_stage;

  typedef struct packed {
    logic        RegWrite;
    logic [2:0]  ALU_op;
    logic        ALUSrc;
    logic        RegDst;
    logic        Branch;
    logic        BranchType;
    logic        MemToReg;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
  } bundle_t;

  typedef struct packed {
    bundle_t b;
    logic    v;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  bundle_t     din;

  logic        RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchType_o;
  logic        MemToReg_o, MemRead_o, MemWrite_o;
  logic [2:0]  ALU_op_o;
  logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o, hazard_o, pc_write_o, ifid_write_o;
  logic [3:0]  bubble_cnt_o, flush_cnt_o;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  expBubble = 4'd0;
  logic [3:0]  expFlush  = 4'd0;

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .RegWrite_i(din.RegWrite), .ALU_op_i(din.ALU_op), .ALUSrc_i(din.ALUSrc),
    .RegDst_i(din.RegDst), .Branch_i(din.Branch), .BranchType_i(din.BranchType),
    .MemToReg_i(din.MemToReg), .MemRead_i(din.MemRead), .MemWrite_i(din.MemWrite),
    .pc_plus4_i(din.pc_plus4), .rs_data_i(din.rs_data), .rt_data_i(din.rt_data),
    .imm_i(din.imm), .rs_addr_i(din.rs_addr), .rt_addr_i(din.rt_addr),
    .rd_addr_i(din.rd_addr), .stall_i(stall_i), .flush_i(flush_i),
    .RegWrite_o(RegWrite_o), .ALU_op_o(ALU_op_o), .ALUSrc_o(ALUSrc_o),
    .RegDst_o(RegDst_o), .Branch_o(Branch_o), .BranchType_o(BranchType_o),
    .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .imm_o(imm_o), .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
    .rd_addr_o(rd_addr_o), .valid_o(valid_o), .hazard_o(hazard_o),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t obsBundle();
    bundle_t o;
    o.RegWrite = RegWrite_o;   o.ALU_op = ALU_op_o;       o.ALUSrc = ALUSrc_o;
    o.RegDst = RegDst_o;       o.Branch = Branch_o;       o.BranchType = BranchType_o;
    o.MemToReg = MemToReg_o;   o.MemRead = MemRead_o;     o.MemWrite = MemWrite_o;
    o.pc_plus4 = pc_plus4_o;   o.rs_data = rs_data_o;     o.rt_data = rt_data_o;
    o.imm = imm_o;             o.rs_addr = rs_addr_o;     o.rt_addr = rt_addr_o;
    o.rd_addr = rd_addr_o;
    return o;
  endfunction

  // Instruction builders
  function automatic bundle_t mkR(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd);
    bundle_t b = '0;
    b.RegWrite = 1'b1; b.ALU_op = 3'b010; b.RegDst = 1'b1;
    b.rs_addr = rs; b.rt_addr = rt; b.rd_addr = rd;
    b.rs_data = rsd; b.rt_data = rtd;
    b.imm = {16'h0000, rs, rd, 6'h20};
    b.pc_plus4 = $urandom;
    return b;
  endfunction

  function automatic bundle_t mkLw(input logic [4:0] rs, rt);
    bundle_t b = '0;
    b.RegWrite = 1'b1; b.ALUSrc = 1'b1; b.MemToReg = 1'b1; b.MemRead = 1'b1;
    b.rs_addr = rs; b.rt_addr = rt; b.imm = 32'd16;
    b.rs_data = $urandom; b.pc_plus4 = $urandom;
    return b;
  endfunction

  function automatic bundle_t mkSw(input logic [4:0] rs, rt, input logic [31:0] rtd);
    bundle_t b = '0;
    b.ALUSrc = 1'b1; b.MemWrite = 1'b1;
    b.rs_addr = rs; b.rt_addr = rt; b.imm = 32'd4;
    b.rs_data = $urandom; b.rt_data = rtd; b.pc_plus4 = $urandom;
    return b;
  endfunction

  function automatic bundle_t mkBeq(input logic [4:0] rs, rt);
    bundle_t b = '0;
    b.Branch = 1'b1; b.ALU_op = 3'b001;
    b.rs_addr = rs; b.rt_addr = rt; b.imm = 32'hFFFF_FFFC;
    b.rs_data = $urandom; b.rt_data = $urandom; b.pc_plus4 = $urandom;
    return b;
  endfunction

  function automatic bundle_t mkAddi(input logic [4:0] rs, rt);
    bundle_t b = '0;
    b.RegWrite = 1'b1; b.ALUSrc = 1'b1;
    b.rs_addr = rs; b.rt_addr = rt; b.imm = 32'd7;
    b.rs_data = $urandom; b.pc_plus4 = $urandom;
    return b;
  endfunction

  task automatic edgeSettle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; din = '0;
    repeat (2) edgeSettle();
    checks++;
    if ({obsBundle(), valid_o} !== '0) begin
      errors++; $display("FAIL reset_regs: got %h want 0", {obsBundle(), valid_o});
    end
    checks++;
    if ({bubble_cnt_o, flush_cnt_o} !== 8'h00) begin
      errors++; $display("FAIL reset_cnt: got %h want 00", {bubble_cnt_o, flush_cnt_o});
    end
    checks++;
    if ({pc_write_o, ifid_write_o} !== 2'b00) begin
      errors++; $display("FAIL reset_pcwrite: got %b want 00", {pc_write_o, ifid_write_o});
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({pc_write_o, ifid_write_o} !== 2'b11) begin
      errors++; $display("FAIL release_pcwrite: got %b want 11", {pc_write_o, ifid_write_o});
    end
  endtask

  task automatic test_capture();
    bundle_t b;
    b = mkR(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    din = b;
    sb.push_back({b, 1'b1});
    edgeSettle();
    e = sb.pop_front();
    checks++;
    if ({obsBundle(), valid_o} !== e) begin
      errors++; $display("FAIL cap_rtype: got %h want %h", {obsBundle(), valid_o}, e);
    end
    checks++;
    if (hazard_o !== 1'b0) begin
      errors++; $display("FAIL cap_hazard: got %b want 0", hazard_o);
    end
  endtask

  task automatic test_load_use();
    bundle_t cons[4];
    bundle_t lw;
    cons[0] = mkR(5'd8, 5'd9, 5'd10, $urandom, $urandom);   // rs match
    cons[1] = mkR(5'd3, 5'd8, 5'd11, $urandom, $urandom);   // rt match via RegDst
    cons[2] = mkSw(5'd1, 5'd8, $urandom);                   // rt match via MemWrite
    cons[3] = mkBeq(5'd2, 5'd8);                            // rt match via Branch
    for (int i = 0; i < 4; i++) begin
      lw = mkLw(5'd4, 5'd8);
      din = lw;
      sb.push_back({lw, 1'b1});
      edgeSettle();
      e = sb.pop_front();
      checks++;
      if ({obsBundle(), valid_o} !== e) begin
        errors++; $display("FAIL lu_load[%0d]: got %h want %h", i, {obsBundle(), valid_o}, e);
      end
      din = cons[i];
      #1;
      checks++;
      if ({hazard_o, pc_write_o, ifid_write_o} !== 3'b100) begin
        errors++; $display("FAIL lu_hazard[%0d]: got %b want 100", i, {hazard_o, pc_write_o, ifid_write_o});
      end
      sb.push_back('0);
      if (expBubble != 4'd15) expBubble++;
      edgeSettle();
      e = sb.pop_front();
      checks++;
      if ({obsBundle(), valid_o} !== e) begin
        errors++; $display("FAIL lu_bubble[%0d]: got %h want %h", i, {obsBundle(), valid_o}, e);
      end
      checks++;
      if (bubble_cnt_o !== expBubble) begin
        errors++; $display("FAIL lu_bubble_cnt[%0d]: got %0d want %0d", i, bubble_cnt_o, expBubble);
      end
      checks++;
      if ({hazard_o, pc_write_o} !== 2'b01) begin
        errors++; $display("FAIL lu_release[%0d]: got %b want 01", i, {hazard_o, pc_write_o});
      end
      sb.push_back({cons[i], 1'b1});
      edgeSettle();
      e = sb.pop_front();
      checks++;
      if ({obsBundle(), valid_o} !== e) begin
        errors++; $display("FAIL lu_consumer[%0d]: got %h want %h", i, {obsBundle(), valid_o}, e);
      end
    end
  endtask

  task automatic test_no_hazard();
    bundle_t seq[4];
    seq[0] = mkLw(5'd4, 5'd0);                              // load to $0
    seq[1] = mkR(5'd0, 5'd5, 5'd6, $urandom, $urandom);     // reads $0
    seq[2] = mkLw(5'd4, 5'd8);
    seq[3] = mkAddi(5'd3, 5'd8);                            // rt=8 is destination only
    for (int i = 0; i < 4; i++) begin
      din = seq[i];
      #1;
      checks++;
      if ({hazard_o, pc_write_o} !== 2'b01) begin
        errors++; $display("FAIL nh_hazard[%0d]: got %b want 01", i, {hazard_o, pc_write_o});
      end
      sb.push_back({seq[i], 1'b1});
      edgeSettle();
      e = sb.pop_front();
      checks++;
      if ({obsBundle(), valid_o} !== e) begin
        errors++; $display("FAIL nh_capture[%0d]: got %h want %h", i, {obsBundle(), valid_o}, e);
      end
    end
    checks++;
    if (bubble_cnt_o !== expBubble) begin
      errors++; $display("FAIL nh_bubble_cnt: got %0d want %0d", bubble_cnt_o, expBubble);
    end
  endtask

  task automatic test_flush_priority();
    bundle_t b;
    // flush together with stall, valid beq in EX
    b = mkBeq(5'd2, 5'd3);
    din = b;
    edgeSettle();
    din = mkR(5'd12, 5'd13, 5'd14, $urandom, $urandom);
    stall_i = 1'b1; flush_i = 1'b1;
    #1;
    checks++;
    if ({pc_write_o, ifid_write_o} !== 2'b00) begin
      errors++; $display("FAIL fl_stall_pcwrite: got %b want 00", {pc_write_o, ifid_write_o});
    end
    sb.push_back('0);
    expFlush++;
    edgeSettle();
    e = sb.pop_front();
    checks++;
    if ({obsBundle(), valid_o} !== e) begin
      errors++; $display("FAIL fl_stall_regs: got %h want %h", {obsBundle(), valid_o}, e);
    end
    checks++;
    if ({bubble_cnt_o, flush_cnt_o} !== {expBubble, expFlush}) begin
      errors++; $display("FAIL fl_stall_cnt: got %h want %h", {bubble_cnt_o, flush_cnt_o}, {expBubble, expFlush});
    end
    // flush together with a load-use hazard
    stall_i = 1'b0; flush_i = 1'b0;
    din = mkLw(5'd4, 5'd8);
    edgeSettle();
    din = mkR(5'd8, 5'd1, 5'd2, $urandom, $urandom);
    flush_i = 1'b1;
    #1;
    checks++;
    if ({hazard_o, pc_write_o} !== 2'b10) begin
      errors++; $display("FAIL fl_haz_comb: got %b want 10", {hazard_o, pc_write_o});
    end
    sb.push_back('0);
    expFlush++;
    edgeSettle();
    flush_i = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({obsBundle(), valid_o} !== e) begin
      errors++; $display("FAIL fl_haz_regs: got %h want %h", {obsBundle(), valid_o}, e);
    end
    checks++;
    if ({bubble_cnt_o, flush_cnt_o} !== {expBubble, expFlush}) begin
      errors++; $display("FAIL fl_haz_cnt: got %h want %h", {bubble_cnt_o, flush_cnt_o}, {expBubble, expFlush});
    end
  endtask

  task automatic test_stall_hold();
    bundle_t sw;
    bundle_t nxt;
    sw = mkSw(5'd5, 5'd6, 32'hDEAD_BEEF);
    din = sw;
    edgeSettle();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = mkR(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd20, $urandom, $urandom);
      #1;
      checks++;
      if ({pc_write_o, ifid_write_o} !== 2'b00) begin
        errors++; $display("FAIL st_pcwrite[%0d]: got %b want 00", i, {pc_write_o, ifid_write_o});
      end
      sb.push_back({sw, 1'b1});
      edgeSettle();
      e = sb.pop_front();
      checks++;
      if ({obsBundle(), valid_o} !== e) begin
        errors++; $display("FAIL st_hold[%0d]: got %h want %h", i, {obsBundle(), valid_o}, e);
      end
    end
    stall_i = 1'b0;
    nxt = mkR(5'd11, 5'd12, 5'd13, $urandom, $urandom);
    din = nxt;
    #1;
    checks++;
    if (pc_write_o !== 1'b1) begin
      errors++; $display("FAIL st_resume_pcwrite: got %b want 1", pc_write_o);
    end
    sb.push_back({nxt, 1'b1});
    edgeSettle();
    e = sb.pop_front();
    checks++;
    if ({obsBundle(), valid_o} !== e) begin
      errors++; $display("FAIL st_resume: got %h want %h", {obsBundle(), valid_o}, e);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      din = mkLw(5'd4, 5'd8);
      edgeSettle();
      din = mkR(5'd8, 5'd9, 5'd10, $urandom, $urandom);
      edgeSettle();
      if (expBubble != 4'd15) expBubble++;
    end
    checks++;
    if (bubble_cnt_o !== 4'd15) begin
      errors++; $display("FAIL sat_bubble: got %0d want 15", bubble_cnt_o);
    end
    checks++;
    if (flush_cnt_o !== expFlush) begin
      errors++; $display("FAIL sat_flush: got %0d want %0d", flush_cnt_o, expFlush);
    end
  endtask

  task automatic test_reset_mid_stall();
    bundle_t nxt;
    din = mkSw(5'd7, 5'd9, $urandom);
    edgeSettle();
    stall_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    checks++;
    if ({obsBundle(), valid_o, bubble_cnt_o, flush_cnt_o, pc_write_o} !== '0) begin
      errors++; $display("FAIL rst_async: got %h want 0", {obsBundle(), valid_o, bubble_cnt_o, flush_cnt_o, pc_write_o});
    end
    #1;
    rst_i = 1'b0; stall_i = 1'b0;
    expBubble = 4'd0; expFlush = 4'd0;
    nxt = mkR(5'd1, 5'd2, 5'd3, $urandom, $urandom);
    din = nxt;
    #1;
    checks++;
    if ({hazard_o, pc_write_o} !== 2'b01) begin
      errors++; $display("FAIL rst_release_pcwrite: got %b want 01", {hazard_o, pc_write_o});
    end
    sb.push_back({nxt, 1'b1});
    edgeSettle();
    e = sb.pop_front();
    checks++;
    if ({obsBundle(), valid_o} !== e) begin
      errors++; $display("FAIL rst_recapture: got %h want %h", {obsBundle(), valid_o}, e);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_no_hazard();
    test_flush_priority();
    test_stall_hold();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline boundary directly downstream of the instruction decoder and register file in the 5-stage pipelined CPU. Latches decoder control bits, register operands, immediate and register addresses for the EX stage. Performs load-use hazard detection and stalls the front end. Inserts bubbles on hazard or branch flush, and keeps saturating performance counters for bubbles and flushes.

Parameters:
DATA_W, 32, width of PC, operand and immediate datapath
CNT_W, 16, width of each performance counter

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous reset, active-high
RegWrite_i  in  1  decoder control
ALU_op_i  in  3  decoder ALU op (000 add, 001 sub/branch, 010 R-type)
ALUSrc_i, RegDst_i, Branch_i, BranchType_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each  decoder controls
pc_plus4_i  in  DATA_W  PC+4 of ID instruction
rs_data_i, rt_data_i  in  DATA_W  register file read data
imm_i  in  DATA_W  sign-extended immediate (funct = imm_i[5:0])
rs_addr_i, rt_addr_i, rd_addr_i  in  5  instruction fields
stall_i  in  1  downstream hold (e.g. memory wait)
flush_i  in  1  branch taken in MEM; kill ID instruction
*_o  out  same  registered copies of every *_i above (RegWrite_o ... rd_addr_o)
valid_o  out  1  EX slot holds a real instruction
hazard_o  out  1  load-use hazard detected this cycle (combinational)
pc_write_o  out  1  PC write enable
ifid_write_o  out  1  IF/ID register write enable
bubble_cnt_o  out  CNT_W  hazard bubbles inserted
flush_cnt_o  out  CNT_W  flushes taken

Behaviour:
- Reset, asynchronous: all registered outputs, valid_o and both counters go to 0 immediately. This state is a bubble.
- uses_rt = RegDst_i | Branch_i | MemWrite_i.
- hazard_o = valid_o & MemRead_o & (rt_addr_o != 0) & ((rt_addr_o == rs_addr_i) | (uses_rt & rt_addr_o == rt_addr_i)). It is purely combinational from current register state and ID inputs.
- pc_write_o = ifid_write_o = ~(hazard_o | stall_i) & ~rst_i. flush_i does not gate them; the PC mux owns redirection.
- Per rising edge, first matching rule wins:
  1. flush_i: load bubble (every *_o = 0, valid_o = 0). flush_cnt += 1.
  2. stall_i: hold all registers unchanged. No counter change.
  3. hazard_o: load bubble. bubble_cnt += 1. The ID instruction stays in IF/ID because ifid_write_o = 0 and re-presents next cycle.
  4. Otherwise: capture all *_i, valid_o = 1.
- Bubble clears data fields as well as controls, so downstream sees deterministic zeros.
- Latency: 1 cycle ID to EX. Exactly one bubble per load-use pair, because after the bubble valid_o = 0 and hazard_o drops.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Simultaneous flush_i and stall_i: flush wins. The instruction is killed even while downstream holds.
- Simultaneous flush_i and hazard: flush wins. Only flush_cnt increments.
- Load to $0 (rt_addr_o = 0) never raises hazard_o.
- Reset mid-stall: outputs clear immediately. After release, pc_write_o = 1 unless a new hazard exists.

Test Plan:
- Reset then a plain capture: assert rst_i, then release; drive an R-type (RegDst=1, ALU_op=010, rs=1, rt=2, rd=3, rs_data=5, rt_data=7). Required next edge: outputs match, valid_o=1, hazard_o=0.
- Load-use: capture lw (MemRead=1, rt=8). Then ID presents add with rs=8. Required: hazard_o=1, pc_write_o=0. Next edge: bubble (valid_o=0, RegWrite_o=0), bubble_cnt=1. Following edge: add captured, hazard_o=0.
- Non-hazard load: lw rt=0 followed by rs=0, and lw rt=8 followed by addi using rt=8 as destination only (uses_rt=0). Required: hazard_o=0 in both cases and no bubble.
- Flush priority: with stall_i=1 and flush_i=1 on the same edge holding a valid beq. Required: valid_o=0, all *_o=0, flush_cnt=1, bubble_cnt unchanged.
- Stall hold: capture sw, then hold stall_i=1 for 3 cycles with changing inputs. Required: outputs frozen at the sw values, pc_write_o=0 throughout. Capture resumes on the first edge with stall_i=0.
- Counter saturation: with CNT_W=4, force 20 load-use hazards. Required: bubble_cnt_o stops at 15.
